// File: rtl/dmem_line_responder_pkg.sv
// Shared widths and FSM encoding for the line responder and its storage.
package dmem_line_responder_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StAck  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_line_ram.sv
// Single-port line storage: synchronous write, synchronous read into an output register.
module line_ram
    import dmem_line_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    // Contents are deliberately never reset.
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Commit a line on an enabled write.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds data for exactly one cycle after an enabled read, zero otherwise.
    always_ff @(posedge clk_i) begin
        if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency line memory responder: one request at a time, ack pulse after LATENCY cycles.
module dmem_line_responder
    import dmem_line_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              write_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;

    logic              done;
    logic              ram_en;
    logic [LINE_W-1:0] ram_rdata;
    logic              unused_addr;

    // Offset and high address bits never select a line; high bits alias by wrap-around.
    assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_W+IdxW], addr_i[OFFSET_W-1:0]};

    // The array access happens on the same edge that enters ACK; reset suppresses it.
    assign done   = (state_q == StBusy) && (cnt_q == CntLast);
    assign ram_en = rst_i && done;

    // Request FSM, latency counter and capture registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= addr_i[OFFSET_W +: IdxW];
                        write_q <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == CntLast) begin
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAck: begin
                    // Requests seen during ACK are ignored; IDLE samples on the next edge.
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    line_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (write_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign ack_o  = ack_q;
    // The RAM read register is zero except in the ACK cycle of a read.
    assign data_o = ram_rdata;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench with an expectation queue keyed by the cycle in which ack must appear.
module tb_dmem_line_responder;

    localparam int unsigned LAT = 10;
    localparam int unsigned DEP = 512;

    typedef struct {
        int          cyc;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    logic [255:0] model [DEP];
    exp_t         sb [$];
    int           cyc = 0;
    int           n_total = 0;
    int           n_pass = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    dmem_line_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEP)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge, then compare outputs at the falling edge against the queue head.
    task automatic step();
        logic         exp_ack;
        logic [255:0] exp_data;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_ack  = 1'b1;
            exp_data = sb[0].data;
            void'(sb.pop_front());
        end else begin
            exp_ack  = 1'b0;
            exp_data = '0;
        end
        chk("ack", {255'd0, ack_o}, {255'd0, exp_ack});
        chk("data", data_o, exp_data);
    endtask

    // Drive a request now; it is sampled at edge cyc+1 and acks in the cycle after cyc+1+LAT.
    task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d);
        exp_t       e;
        logic [8:0] idx;
        idx      = a[13:5];
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        e.cyc    = cyc + 1 + LAT;
        if (w) begin
            e.data     = '0;
            model[idx] = d;
        end else begin
            e.data = model[idx];
        end
        sb.push_back(e);
    endtask

    // Step until every expected ack has been seen, bounded; then release the request.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", {255'd0, sb.size() == 0}, {255'd0, 1'b1});
        sb.delete();
        enable_i = 1'b0;
        step();
        step();
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        exp_t         e;
        logic [255:0] d;
        logic [31:0]  a;

        rst_i    = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        for (int i = 0; i < DEP; i++) begin
            model[i]              = {8{32'hA5A5_0000 | 32'(i)}};
            dut.u_ram.mem_q[i]    = model[i];
        end

        // Reset state: outputs quiet.
        step();
        step();
        rst_i = 1'b1;
        step();

        // Read of line 2 via 0x40; zero before and after the single ack cycle.
        issue(1'b0, 32'h0000_0040, '0);
        drain();

        // Write then read back the same line.
        issue(1'b1, 32'h0000_0100, {8{32'hDEADBEEF}});
        drain();
        issue(1'b0, 32'h0000_0100, '0);
        drain();

        // Enable held high across two requests: ACK goes to IDLE, IDLE samples on the
        // following edge, so consecutive requests start LAT+2 edges apart.
        issue(1'b0, 32'h0000_0040, '0);
        e.cyc  = sb[0].cyc + LAT + 2;
        e.data = model[2];
        sb.push_back(e);
        while (cyc < e.cyc) step();
        enable_i = 1'b0;
        drain();

        // Reset in BUSY cycle 5 of a write aborts it: no ack, line left untouched.
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_0200;
        data_i   = {8{32'hBAD0_BAD0}};
        for (int i = 0; i < 6; i++) step();
        rst_i = 1'b0;
        step();
        rst_i    = 1'b1;
        enable_i = 1'b0;
        for (int i = 0; i < LAT + 4; i++) step();
        issue(1'b0, 32'h0000_0200, '0);
        drain();

        // Index wrap and offset bits ignored: 0x4000 and 0x1F both select line 0.
        issue(1'b1, 32'h0000_4000, {8{32'h1234_5678}});
        drain();
        issue(1'b0, 32'h0000_001F, '0);
        chk("wrap_expect", sb[0].data, {8{32'h1234_5678}});
        drain();

        // Address change during BUSY is ignored; response stays line 2.
        issue(1'b0, 32'h0000_0040, '0);
        for (int i = 0; i < 4; i++) step();
        addr_i  = 32'h0000_0080;
        write_i = 1'b1;
        drain();

        // A few random writes/reads checked against the line model.
        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            d = rand_line();
            issue(1'b1, a, d);
            drain();
            issue(1'b0, {$urandom() & 32'hFFFF_C000} | {18'd0, a[13:5], 5'(($urandom()))}, '0);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
